// File: rtl/irq_controller_pkg.sv
// Shared definitions for the IO interrupt controller: FSM state codes, default sizing, source map.
package irq_controller_pkg;

  localparam int DEF_N_SOURCES = 8;
  localparam int DEF_ID_W      = 3;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ASSERT = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;

  localparam int IRQ_TIMER1 = 0;
  localparam int IRQ_TIMER2 = 1;
  localparam int IRQ_UART   = 2;
  localparam int IRQ_GPIO   = 3;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-wins priority encoder over the eligible interrupt set.
module irq_prio_enc #(
  parameter int N_SOURCES = 8,
  parameter int ID_W      = 3
) (
  input  logic [N_SOURCES-1:0] eligible,
  output logic [ID_W-1:0]      id,
  output logic                 any
);

  always_comb begin
    id  = '0;
    any = |eligible;
    // Scan downward so the lowest set index is the last one written.
    for (int i = N_SOURCES - 1; i >= 0; i--) begin
      if (eligible[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Edge-detecting, maskable, fixed-priority interrupt controller with explicit CPU acknowledge.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int N_SOURCES = DEF_N_SOURCES,
  parameter int ID_W      = DEF_ID_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_SOURCES-1:0] irq_in,
  input  logic                 mask_we,
  input  logic [N_SOURCES-1:0] mask_data,
  input  logic                 int_ack,
  output logic                 int_out,
  output logic [ID_W-1:0]      int_id,
  output logic [N_SOURCES-1:0] pending_out,
  output logic [N_SOURCES-1:0] mask_out
);

  logic [1:0]           state_q, state_d;
  logic [N_SOURCES-1:0] irq_prev_q, irq_prev_d;
  logic [N_SOURCES-1:0] pending_q, pending_d;
  logic [N_SOURCES-1:0] mask_q, mask_d;
  logic [ID_W-1:0]      int_id_q, int_id_d;

  logic [N_SOURCES-1:0] irq_edge;
  logic [N_SOURCES-1:0] ack_clr;
  logic [N_SOURCES-1:0] eligible;
  logic [ID_W-1:0]      sel_id;
  logic                 sel_any;
  logic                 ack_acc;

  assign eligible = pending_q & ~mask_q;
  assign ack_acc  = (state_q == S_ASSERT) && int_ack;

  irq_prio_enc #(
    .N_SOURCES(N_SOURCES),
    .ID_W     (ID_W)
  ) u_prio_enc (
    .eligible(eligible),
    .id      (sel_id),
    .any     (sel_any)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      irq_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      int_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      irq_prev_q <= irq_prev_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      int_id_q   <= int_id_d;
    end
  end

  // Applying the ack clear before OR-ing in edges makes a same-cycle re-trigger win.
  always_comb begin
    irq_prev_d = irq_in;
    irq_edge   = irq_in & ~irq_prev_q;
    ack_clr    = ack_acc ? ({{(N_SOURCES-1){1'b0}}, 1'b1} << int_id_q) : '0;
    pending_d  = (pending_q & ~ack_clr) | irq_edge;
    mask_d     = mask_we ? mask_data : mask_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (sel_any) state_d = S_ASSERT;
      S_ASSERT: if (int_ack) state_d = S_GAP;
      S_GAP:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    int_out  = (state_q == S_ASSERT);
    int_id_d = int_id_q;
    if (state_q == S_IDLE && sel_any) int_id_d = sel_id;
  end

  assign int_id      = int_id_q;
  assign pending_out = pending_q;
  assign mask_out    = mask_q;

endmodule

// File: tb/tb_irq_controller.sv
// Randomized + directed scoreboard bench for irq_controller against a behavioural model.
module tb_irq_controller;
  import irq_controller_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq_in;
  logic       mask_we;
  logic [7:0] mask_data;
  logic       int_ack;
  logic       int_out;
  logic [2:0] int_id;
  logic [7:0] pending_out;
  logic [7:0] mask_out;

  always #5 clk = ~clk;

  irq_controller #(.N_SOURCES(8), .ID_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_data  (mask_data),
    .int_ack    (int_ack),
    .int_out    (int_out),
    .int_id     (int_id),
    .pending_out(pending_out),
    .mask_out   (mask_out)
  );

  typedef struct {
    logic       o;
    logic [2:0] id;
    logic [7:0] pend;
    logic [7:0] mask;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc_n = 0;

  // Behavioural model state: what the CPU should see.
  bit   m_prev[8];
  bit   m_pend[8];
  bit   m_mask[8];
  bit   m_presenting;
  bit   m_in_gap;
  int   m_id;

  task automatic model_step(input logic [7:0] irq, input logic mwe, input logic [7:0] md,
                            input logic ack, input logic rst_n);
    int  lowest;
    bit  fresh[8];
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        m_prev[i] = 0; m_pend[i] = 0; m_mask[i] = 0;
      end
      m_presenting = 0; m_in_gap = 0; m_id = 0;
      return;
    end
    lowest = -1;
    for (int i = 7; i >= 0; i--) if (m_pend[i] && !m_mask[i]) lowest = i;
    for (int i = 0; i < 8; i++) begin
      fresh[i]  = irq[i] && !m_prev[i];
      m_prev[i] = irq[i];
    end
    if (m_presenting && ack) m_pend[m_id] = 0;
    for (int i = 0; i < 8; i++) if (fresh[i]) m_pend[i] = 1;
    if (m_presenting) begin
      if (ack) begin m_presenting = 0; m_in_gap = 1; end
    end else if (m_in_gap) begin
      m_in_gap = 0;
    end else if (lowest >= 0) begin
      m_presenting = 1;
      m_id = lowest;
    end
    if (mwe) for (int i = 0; i < 8; i++) m_mask[i] = md[i];
  endtask

  task automatic cyc(input logic [7:0] irq, input logic mwe, input logic [7:0] md,
                     input logic ack, input logic rst_n);
    exp_t e;
    @(negedge clk);
    irq_in = irq; mask_we = mwe; mask_data = md; int_ack = ack; reset = rst_n;
    @(posedge clk);
    model_step(irq, mwe, md, ack, rst_n);
    cyc_n++;
    e.o = m_presenting;
    e.id = 3'(m_id);
    for (int i = 0; i < 8; i++) begin
      e.pend[i] = m_pend[i];
      e.mask[i] = m_mask[i];
    end
    e.cyc = cyc_n;
    exp_q.push_back(e);
  endtask

  // Runs n cycles holding irq, acknowledging whatever the model says is presented.
  task automatic auto_ack(input logic [7:0] irq, input int n);
    for (int k = 0; k < n; k++) cyc(irq, 1'b0, 8'h00, m_presenting, 1'b1);
  endtask

  task automatic chk(input string name, input int cyc_no, input logic [7:0] act, input logic [7:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_no, act, expv);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("int_out", e.cyc, {7'b0, int_out}, {7'b0, e.o});
        chk("int_id", e.cyc, {5'b0, int_id}, {5'b0, e.id});
        chk("pending_out", e.cyc, pending_out, e.pend);
        chk("mask_out", e.cyc, mask_out, e.mask);
      end
    end
  end

  initial begin : stimulus
    int bound;
    irq_in = '0; mask_we = 0; mask_data = '0; int_ack = 0; reset = 0;
    cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    // Single source on the UART line.
    cyc(8'h01 << IRQ_UART, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    auto_ack(8'h00, 3);

    // Simultaneous sources 5 and 1.
    cyc(8'h22, 1'b0, 8'h00, 1'b0, 1'b1);
    auto_ack(8'h00, 10);

    // Masked source accumulates, then unmask.
    cyc(8'h00, 1'b1, 8'h01, 1'b0, 1'b1);
    cyc(8'h01, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b1, 8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    auto_ack(8'h00, 4);

    // Set wins over ack on source 3; also a stray ack in idle.
    cyc(8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    cyc(8'h08, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(8'h08, 1'b0, 8'h00, 1'b1, 1'b1);
    cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    auto_ack(8'h00, 4);

    // Level held high counts once.
    auto_ack(8'h10, 20);
    auto_ack(8'h00, 4);

    // Reset mid-assertion with a non-zero mask.
    cyc(8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
    cyc(8'h40, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      logic [7:0] r_irq;
      logic       r_ack;
      r_irq = 8'($urandom) & 8'($urandom) & 8'($urandom);
      r_ack = m_presenting ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      cyc(r_irq, ($urandom_range(0, 9) == 0), 8'($urandom) & 8'($urandom),
          r_ack, ($urandom_range(0, 149) != 0));
    end

    bound = 0;
    while (exp_q.size() > 0 && bound < 10) begin
      @(negedge clk);
      bound++;
    end
    @(posedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
